scan_chain_ctrl: RTL and testbench

- Sequences a single shift-right scan chain (parallel-load via d, serial via sin/sout, controls sen/ce) for host-driven capture, unload and reload.
- Host requests an operation; the block drives capture and CHAIN_LEN shift cycles, streaming unloaded bits out as WORD_W words and reload bits in as WORD_W words, both over valid/ready.
- Sits between the debug/host interface and the chain. Returns chain control to functional logic when idle.

---
 rtl/scan_chain_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
//
// Sequences one shift-right scan chain on behalf of a host. An operation
// optionally captures the chain (parallel load of d), then shifts the whole
// chain CHAIN_LEN times. The bits that fall out of scan_sout are packed LSB
// first into WORD_W-bit words on the dout stream. The bits shifted in on
// scan_sin are taken LSB first from words on the din stream. When idle, the
// chain clock enable is handed back to functional logic via func_ce.
//
// Ports
//   clk, clr          clock; asynchronous active-high reset
//   start, mode       operation request (IDLE only); mode 0 = capture+shift,
//                     mode 1 = shift only
//   abort             cancel any running operation, no done pulse
//   busy, done        busy in every non-idle state; one-cycle completion pulse
//   func_ce           functional clock enable, passed to scan_ce when idle
//   scan_sen/ce/sin   chain controls (combinational from state and buffers)
//   scan_sout         chain serial output (chain q[0])
//   din/_valid/_ready reload word stream, consumed LSB first
//   dout/_valid/_ready unloaded word stream, earliest bit in the LSB
// -----------------------------------------------------------------------------
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 6
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              func_ce,
  output logic              scan_sen,
  output logic              scan_ce,
  output logic              scan_sin,
  input  logic              scan_sout,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  // Buffer bit counters must be able to hold the value WORD_W itself.
  localparam int OW = $clog2(WORD_W + 1);
  localparam logic [OW-1:0]    WORD_FULL = OW'(WORD_W);
  localparam logic [OW-1:0]    O_ONE     = OW'(1);
  localparam logic [CNT_W-1:0] ALL_BITS  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_next;

  // Input buffer: one din word, shifted right as its bits are consumed;
  // ibuf_cnt is the number of bits still unused.
  logic [WORD_W-1:0] ibuf_word;
  logic [OW-1:0]     ibuf_cnt;

  // Output buffer: bits enter at the MSB and move down, so after WORD_W
  // shifts the earliest bit sits in the LSB.
  logic [WORD_W-1:0] obuf_data;
  logic [OW-1:0]     obuf_cnt;

  logic [CNT_W-1:0]  bit_cnt;

  logic              abort_hit;
  logic              ibuf_has_bit;
  logic              obuf_pend;
  logic              dout_free;
  logic              obuf_xfer;
  logic              obuf_blocked;
  logic              shift_fire;
  logic              last_fire;
  logic              din_take;
  logic [WORD_W-1:0] obuf_base;
  logic [OW-1:0]     obuf_cnt_base;
  logic [WORD_W-1:0] obuf_shifted;
  logic [WORD_W-1:0] obuf_aligned;

  assign abort_hit    = abort && (state != IDLE);
  assign ibuf_has_bit = (ibuf_cnt != '0);

  // obuf is ready to move to dout when it is full, or when the chain is
  // exhausted and a partial word remains.
  assign obuf_pend    = (obuf_cnt == WORD_FULL) ||
                        ((bit_cnt == ALL_BITS) && (obuf_cnt != '0));
  assign dout_free    = !dout_valid || dout_ready;
  assign obuf_xfer    = obuf_pend && dout_free && ((state == SHIFT) || (state == FLUSH));
  assign obuf_blocked = (obuf_cnt == WORD_FULL) && dout_valid && !dout_ready;

  assign shift_fire   = (state == SHIFT) && ibuf_has_bit && !obuf_blocked;
  assign last_fire    = shift_fire && (bit_cnt == LAST_BIT);

  assign din_ready    = (state == SHIFT) && !ibuf_has_bit;
  assign din_take     = din_valid && din_ready;

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  // A partial final word sits in the upper bits of obuf; move it down so
  // the earliest bit lands in the LSB and the top is zero-padded.
  assign obuf_aligned = obuf_data >> (WORD_FULL - obuf_cnt);

  // A transfer empties obuf at the same edge a new bit may enter it, so the
  // incoming bit is merged into an already-cleared buffer (no bubble).
  always_comb begin
    obuf_base     = obuf_xfer ? '0 : obuf_data;
    obuf_cnt_base = obuf_xfer ? '0 : obuf_cnt;
    obuf_shifted  = obuf_base >> 1;
    obuf_shifted[WORD_W-1] = scan_sout;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the chain control outputs. abort overrides every
  // transition out of a non-idle state.
  always_comb begin
    state_next = state;
    scan_sen   = 1'b0;
    scan_ce    = 1'b0;
    scan_sin   = 1'b0;
    case (state)
      IDLE: begin
        scan_ce = func_ce;
        if (start) begin
          state_next = mode ? SHIFT : CAPTURE;
        end
      end
      CAPTURE: begin
        scan_ce    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        scan_sen = 1'b1;
        scan_ce  = shift_fire;
        scan_sin = ibuf_word[0] && ibuf_has_bit;
        if (last_fire) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if ((obuf_cnt == '0) && dout_free) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_next = IDLE;
    end
  end

  // Leftover din bits after the final shift are discarded here.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ibuf_word <= '0;
      ibuf_cnt  <= '0;
    end else if (abort_hit || last_fire || (state != SHIFT)) begin
      ibuf_word <= '0;
      ibuf_cnt  <= '0;
    end else if (din_take) begin
      ibuf_word <= din;
      ibuf_cnt  <= WORD_FULL;
    end else if (shift_fire) begin
      ibuf_word <= ibuf_word >> 1;
      ibuf_cnt  <= ibuf_cnt - O_ONE;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      obuf_data <= '0;
      obuf_cnt  <= '0;
    end else if (abort_hit) begin
      obuf_data <= '0;
      obuf_cnt  <= '0;
    end else if (shift_fire) begin
      obuf_data <= obuf_shifted;
      obuf_cnt  <= obuf_cnt_base + O_ONE;
    end else begin
      obuf_data <= obuf_base;
      obuf_cnt  <= obuf_cnt_base;
    end
  end

  // dout only changes on a transfer, which requires the slot to be free,
  // so a pending word stays stable until it is accepted.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (abort_hit) begin
      dout_valid <= 1'b0;
    end else if (obuf_xfer) begin
      dout       <= obuf_aligned;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // The shift count restarts whenever the block is idle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
    end else if (shift_fire) begin
      bit_cnt <= bit_cnt + C_ONE;
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_ctrl
//
// Bench for scan_chain_ctrl. A behavioural scan chain sits on the chain
// controls. Expected dout words are slices of the chain value present when
// the shift starts; the expected final chain is the din bit stream laid out
// from q[0] upward. A second 12-bit instance covers the partial final word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_chain_ctrl;

  localparam int N  = 40;
  localparam int W  = 8;
  localparam int NW = 5;

  logic         clk = 1'b0;
  logic         clr;
  logic         start, mode, abort, func_ce;
  logic         busy, done;
  logic         scan_sen, scan_ce, scan_sin, scan_sout;
  logic [W-1:0] din, dout;
  logic         din_valid, din_ready, dout_valid, dout_ready;

  logic         p_start, p_busy, p_done;
  logic         p_sen, p_ce, p_sin, p_sout;
  logic [W-1:0] p_din, p_dout;
  logic         p_din_valid, p_din_ready, p_dout_valid, p_dout_ready;

  logic [N-1:0] chain_q, chain_d;
  logic [11:0]  p_chain_q, p_chain_d;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] din_words [NW];
  logic [W-1:0] got_words [$];
  int           shifts, captures, dones, din_taken;
  bit           stable_ok;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(N), .WORD_W(W), .CNT_W(6)) u_dut (
    .clk(clk), .clr(clr), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .done(done), .func_ce(func_ce),
    .scan_sen(scan_sen), .scan_ce(scan_ce), .scan_sin(scan_sin), .scan_sout(scan_sout),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  scan_chain_ctrl #(.CHAIN_LEN(12), .WORD_W(W), .CNT_W(4)) u_dut12 (
    .clk(clk), .clr(clr), .start(p_start), .mode(1'b0), .abort(1'b0),
    .busy(p_busy), .done(p_done), .func_ce(1'b0),
    .scan_sen(p_sen), .scan_ce(p_ce), .scan_sin(p_sin), .scan_sout(p_sout),
    .din(p_din), .din_valid(p_din_valid), .din_ready(p_din_ready),
    .dout(p_dout), .dout_valid(p_dout_valid), .dout_ready(p_dout_ready)
  );

  // Behavioural chains: parallel load of d, or shift right with sin at the MSB.
  assign scan_sout = chain_q[0];
  assign p_sout    = p_chain_q[0];

  always @(posedge clk) begin
    if (scan_ce) chain_q <= scan_sen ? {scan_sin, chain_q[N-1:1]} : chain_d;
    if (p_ce)    p_chain_q <= p_sen ? {p_sin, p_chain_q[11:1]} : p_chain_d;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one full operation with the given flow-control pattern and records
  // what crossed each interface.
  task automatic applyStimulus(input bit op_mode, input int din_gap, input int stall_len,
                               input bit rand_ready, input bit rand_valid);
    int           gap, stall;
    bit           last_blocked;
    logic [W-1:0] last_dout;
    got_words.delete();
    shifts = 0; captures = 0; dones = 0; din_taken = 0; stable_ok = 1'b1;
    gap = 0; stall = 0; last_blocked = 1'b0; last_dout = '0;
    din_valid = 1'b0; dout_ready = 1'b1;
    start = 1'b1; mode = op_mode;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (gap > 0) begin
        gap--;
        din_valid = 1'b0;
      end else begin
        din_valid = (din_taken < NW) && (!rand_valid || ($urandom_range(3) != 0));
      end
      if (din_taken < NW) din = din_words[din_taken];
      if (stall > 0) begin
        stall--;
        dout_ready = 1'b0;
      end else begin
        dout_ready = !rand_ready || ($urandom_range(2) != 0);
      end
      @(negedge clk);
      if (last_blocked && (!dout_valid || dout !== last_dout)) stable_ok = 1'b0;
      last_blocked = dout_valid && !dout_ready;
      last_dout = dout;
      if (scan_ce && scan_sen) shifts++;
      if (busy && scan_ce && !scan_sen) captures++;
      if (done) dones++;
      if (dout_valid && dout_ready) begin
        got_words.push_back(dout);
        if (got_words.size() == 1) stall = stall_len;
      end
      if (din_valid && din_ready) begin
        din_taken++;
        gap = din_gap;
      end
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (busy) checkOutput("op_timeout", 64'(busy), 64'(0));
    @(posedge clk); #1;
    din_valid = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic checkResult(input string tag, input bit op_mode, input logic [N-1:0] pre_chain);
    logic [N-1:0] stream;
    logic [W-1:0] exp_word;
    for (int i = 0; i < N; i++) stream[i] = din_words[i / W][i % W];
    checkOutput($sformatf("%s:word_count", tag), 64'(got_words.size()), 64'(NW));
    for (int k = 0; k < NW && k < got_words.size(); k++) begin
      exp_word = W'(pre_chain >> (W * k));
      checkOutput($sformatf("%s:word%0d", tag, k), 64'(got_words[k]), 64'(exp_word));
    end
    checkOutput($sformatf("%s:shifts", tag), 64'(shifts), 64'(N));
    checkOutput($sformatf("%s:captures", tag), 64'(captures), op_mode ? 64'(0) : 64'(1));
    checkOutput($sformatf("%s:done_pulses", tag), 64'(dones), 64'(1));
    checkOutput($sformatf("%s:din_words", tag), 64'(din_taken), 64'(NW));
    checkOutput($sformatf("%s:chain", tag), 64'(chain_q), 64'(stream));
    checkOutput($sformatf("%s:dout_stable", tag), 64'(stable_ok), 64'(1));
  endtask

  task automatic abortTest();
    int seen = 0;
    int done_seen = 0;
    din_valid = 1'b0; dout_ready = 1'b1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 500 && seen < 17; cyc++) begin
      din_valid = 1'b1;
      din = W'($urandom());
      @(negedge clk);
      if (scan_ce && scan_sen) seen++;
      @(posedge clk); #1;
    end
    checkOutput("abort:shifts_before", 64'(seen), 64'(17));
    din_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort:busy", 64'(busy), 64'(0));
    checkOutput("abort:dout_valid", 64'(dout_valid), 64'(0));
    checkOutput("abort:din_ready", 64'(din_ready), 64'(0));
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort:no_done", 64'(done_seen), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic clrTest();
    din_valid = 1'b1; dout_ready = 1'b0;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      din = W'($urandom());
      @(posedge clk); #1;
    end
    checkOutput("clr:busy_before", 64'(busy), 64'(1));
    checkOutput("clr:valid_before", 64'(dout_valid), 64'(1));
    #3 clr = 1'b1;
    #1;
    checkOutput("clr:busy", 64'(busy), 64'(0));
    checkOutput("clr:dout_valid", 64'(dout_valid), 64'(0));
    checkOutput("clr:dout", 64'(dout), 64'(0));
    checkOutput("clr:din_ready", 64'(din_ready), 64'(0));
    checkOutput("clr:scan_sen", 64'(scan_sen), 64'(0));
    checkOutput("clr:scan_ce", 64'(scan_ce), 64'(0));
    #1 clr = 1'b0;
    din_valid = 1'b0; dout_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic partialTest();
    logic [W-1:0] pw [2];
    logic [W-1:0] exp_w [2];
    logic [W-1:0] got [$];
    int taken = 0;
    int sh = 0;
    int dn = 0;
    pw[0] = W'($urandom());
    pw[1] = W'($urandom());
    exp_w[0] = 8'hBC;
    exp_w[1] = 8'h0A;
    p_chain_d = 12'hABC;
    p_start = 1'b1;
    @(posedge clk); #1;
    p_start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      p_din_valid = (taken < 2);
      if (taken < 2) p_din = pw[taken];
      @(negedge clk);
      if (p_din_valid && p_din_ready) taken++;
      if (p_dout_valid && p_dout_ready) got.push_back(p_dout);
      if (p_ce && p_sen) sh++;
      if (p_done) dn++;
      if (!p_busy) break;
      @(posedge clk); #1;
    end
    if (p_busy) checkOutput("partial:timeout", 64'(p_busy), 64'(0));
    @(posedge clk); #1;
    p_din_valid = 1'b0;
    checkOutput("partial:word_count", 64'(got.size()), 64'(2));
    for (int k = 0; k < 2 && k < got.size(); k++)
      checkOutput($sformatf("partial:word%0d", k), 64'(got[k]), 64'(exp_w[k]));
    checkOutput("partial:din_words", 64'(taken), 64'(2));
    checkOutput("partial:shifts", 64'(sh), 64'(12));
    checkOutput("partial:done_pulses", 64'(dn), 64'(1));
    checkOutput("partial:chain", 64'(p_chain_q), 64'({pw[1][3:0], pw[0]}));
  endtask

  initial begin
    logic [N-1:0] pre;
    bit           m;
    clr = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; func_ce = 1'b0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b1; chain_d = '0;
    p_start = 1'b0; p_din = '0; p_din_valid = 1'b0; p_dout_ready = 1'b1; p_chain_d = '0;
    #12;
    checkOutput("reset:busy", 64'(busy), 64'(0));
    checkOutput("reset:done", 64'(done), 64'(0));
    checkOutput("reset:dout_valid", 64'(dout_valid), 64'(0));
    checkOutput("reset:din_ready", 64'(din_ready), 64'(0));
    checkOutput("reset:dout", 64'(dout), 64'(0));
    checkOutput("reset:scan_sen", 64'(scan_sen), 64'(0));
    func_ce = 1'b1;
    #1 checkOutput("idle:ce_follows_1", 64'(scan_ce), 64'(1));
    func_ce = 1'b0;
    #1 checkOutput("idle:ce_follows_0", 64'(scan_ce), 64'(0));
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;

    $display("[TB] capture and unload");
    chain_d = 40'h12_3456_789A;
    for (int k = 0; k < NW; k++) din_words[k] = '0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    checkResult("capture", 1'b0, chain_d);

    $display("[TB] round trip");
    for (int k = 0; k < NW && k < got_words.size(); k++) din_words[k] = got_words[k];
    pre = chain_q;
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    checkResult("roundtrip", 1'b1, pre);
    checkOutput("roundtrip:restored", 64'(chain_q), 64'h12_3456_789A);

    $display("[TB] backpressure");
    chain_d = N'({$urandom(), $urandom()});
    for (int k = 0; k < NW; k++) din_words[k] = W'($urandom());
    applyStimulus(1'b0, 0, 20, 1'b0, 1'b0);
    checkResult("backpressure", 1'b0, chain_d);

    $display("[TB] input starvation");
    for (int k = 0; k < NW; k++) din_words[k] = W'($urandom());
    pre = chain_q;
    applyStimulus(1'b1, 3, 0, 1'b0, 1'b0);
    checkResult("starve", 1'b1, pre);

    $display("[TB] random operations");
    for (int r = 0; r < 6; r++) begin
      m = 1'($urandom_range(1));
      chain_d = N'({$urandom(), $urandom()});
      for (int k = 0; k < NW; k++) din_words[k] = W'($urandom());
      pre = m ? chain_q : chain_d;
      applyStimulus(m, $urandom_range(2), 0, 1'b1, 1'b1);
      checkResult($sformatf("rand%0d", r), m, pre);
    end

    $display("[TB] abort");
    abortTest();

    $display("[TB] async clear");
    clrTest();

    $display("[TB] partial word");
    partialTest();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
